elevator_car_ctrl: RTL

//  Car-side motion/door controller; consumer of the request sorter's nextfloor output.

---
 rtl/elevator_car_ctrl.sv | 154 +++++++++++++++
 1 files changed

// File: rtl/elevator_car_ctrl.sv
// Car motion/door controller: steps one floor per TRAVEL_CYCLES toward the latched target, then cycles the door.
// Registered outputs, one cycle after the deciding edge; no backpressure, nextfloor is sampled every cycle.
module elevator_car_ctrl #(
  parameter int FLOOR_W           = 16,
  parameter int MIN_FLOOR         = 0,
  parameter int MAX_FLOOR         = 15,
  parameter int TRAVEL_CYCLES     = 4,
  parameter int DOOR_OPEN_CYCLES  = 8,
  parameter int DOOR_CLOSE_CYCLES = 2
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [FLOOR_W-1:0] nextfloor,
  input  logic               hold,
  output logic [FLOOR_W-1:0] current_floor,
  output logic               moving_up,
  output logic               moving_down,
  output logic               door_open,
  output logic               door_closing,
  output logic               arrived,
  output logic               fault,
  output logic [15:0]        floor_step_count
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_MOVING,
    S_DOOR_OPEN,
    S_DOOR_CLOSE
  } state_t;

  localparam int TMR_W = 16;
  localparam logic [FLOOR_W-1:0] MIN_F       = FLOOR_W'(MIN_FLOOR);
  localparam logic [FLOOR_W-1:0] SPAN_F      = FLOOR_W'(MAX_FLOOR - MIN_FLOOR);
  localparam logic [TMR_W-1:0]   TRAVEL_LAST = TMR_W'(TRAVEL_CYCLES - 1);
  localparam logic [TMR_W-1:0]   OPEN_LAST   = TMR_W'(DOOR_OPEN_CYCLES - 1);
  localparam logic [TMR_W-1:0]   CLOSE_LAST  = TMR_W'(DOOR_CLOSE_CYCLES - 1);

  state_t             state_q;
  logic [FLOOR_W-1:0] floor_q;
  logic [FLOOR_W-1:0] target_q;
  logic [TMR_W-1:0]   timer_q;
  logic               up_q;
  logic               dn_q;
  logic               open_q;
  logic               closing_q;
  logic               arrived_q;
  logic               fault_q;
  logic [15:0]        steps_q;

  logic               nf_in_range;
  logic               nf_ahead;
  logic [FLOOR_W-1:0] step_floor_d;
  logic [FLOOR_W-1:0] step_target_d;

  // Offset-and-span range test: values below MIN wrap to large numbers and fail the compare.
  assign nf_in_range   = (nextfloor - MIN_F) <= SPAN_F;
  assign step_floor_d  = up_q ? (floor_q + 1'b1) : (floor_q - 1'b1);
  assign nf_ahead      = up_q ? (nextfloor >= step_floor_d) : (nextfloor <= step_floor_d);
  assign step_target_d = (nf_in_range && nf_ahead) ? nextfloor : target_q;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q   <= S_IDLE;
      floor_q   <= MIN_F;
      target_q  <= '0;
      timer_q   <= '0;
      up_q      <= 1'b0;
      dn_q      <= 1'b0;
      open_q    <= 1'b0;
      closing_q <= 1'b0;
      arrived_q <= 1'b0;
      fault_q   <= 1'b0;
      steps_q   <= '0;
    end else begin
      arrived_q <= 1'b0;
      case (state_q)
        S_IDLE: begin
          if (!nf_in_range) begin
            fault_q <= 1'b1;
          end else begin
            fault_q <= 1'b0;
            if (nextfloor != floor_q) begin
              target_q <= nextfloor;
              up_q     <= nextfloor > floor_q;
              dn_q     <= nextfloor < floor_q;
              timer_q  <= '0;
              state_q  <= S_MOVING;
            end
          end
        end
        S_MOVING: begin
          if (timer_q == TRAVEL_LAST) begin
            timer_q  <= '0;
            floor_q  <= step_floor_d;
            steps_q  <= steps_q + 16'd1;
            target_q <= step_target_d;
            if (step_target_d == step_floor_d) begin
              arrived_q <= 1'b1;
              up_q      <= 1'b0;
              dn_q      <= 1'b0;
              open_q    <= 1'b1;
              state_q   <= S_DOOR_OPEN;
            end
          end else begin
            timer_q <= timer_q + 1'b1;
          end
        end
        S_DOOR_OPEN: begin
          if (hold) begin
            timer_q <= '0;
          end else if (timer_q == OPEN_LAST) begin
            timer_q   <= '0;
            open_q    <= 1'b0;
            closing_q <= 1'b1;
            state_q   <= S_DOOR_CLOSE;
          end else begin
            timer_q <= timer_q + 1'b1;
          end
        end
        S_DOOR_CLOSE: begin
          // A hold press while closing reopens the door with a fresh open period.
          if (hold) begin
            timer_q   <= '0;
            closing_q <= 1'b0;
            open_q    <= 1'b1;
            state_q   <= S_DOOR_OPEN;
          end else if (timer_q == CLOSE_LAST) begin
            timer_q   <= '0;
            closing_q <= 1'b0;
            state_q   <= S_IDLE;
          end else begin
            timer_q <= timer_q + 1'b1;
          end
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign current_floor    = floor_q;
  assign moving_up        = up_q;
  assign moving_down      = dn_q;
  assign door_open        = open_q;
  assign door_closing     = closing_q;
  assign arrived          = arrived_q;
  assign fault            = fault_q;
  assign floor_step_count = steps_q;

  a_dir_exclusive: assert property (@(posedge clk) disable iff (!rst_n) !(up_q && dn_q));
  a_floor_range:   assert property (@(posedge clk) disable iff (!rst_n) (floor_q - MIN_F) <= SPAN_F);
  a_door_exclusive: assert property (@(posedge clk) disable iff (!rst_n) !(open_q && closing_q));

endmodule
